// File: rtl/rfg_protocol_pkg.sv
// Types and byte-order helpers for the RFG byte protocol.
// Both the initiator and the target blocks import this package.
package rfg_protocol_pkg;

    typedef struct packed {
        logic [3:0] vchannel;
        logic       rsvd;
        logic       address_increment;
        logic       read;
        logic       write;
    } header_t;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        ADDRESS,
        LENA,
        LENB,
        WRITE_DATA,
        READ_WAIT
    } state_t;

    localparam int unsigned BYTE_HEADER  = 0;
    localparam int unsigned BYTE_ADDRESS = 1;
    localparam int unsigned BYTE_LEN_LSB = 2;
    localparam int unsigned BYTE_LEN_MSB = 3;

    function automatic header_t make_header(input logic write, input logic incr,
                                            input logic [3:0] vch);
        header_t h;
        h.vchannel          = vch;
        h.rsvd              = 1'b0;
        h.address_increment = incr;
        h.read              = ~write;
        h.write             = write;
        return h;
    endfunction

    function automatic logic [7:0] frame_byte(input int unsigned idx, input header_t hdr,
                                              input logic [7:0] addr, input logic [15:0] len);
        case (idx)
            BYTE_HEADER:  return hdr;
            BYTE_ADDRESS: return addr;
            BYTE_LEN_LSB: return len[7:0];
            default:      return len[15:8];
        endcase
    endfunction

endpackage

// File: rtl/rfg_axis_protocol_initiator.sv
// Initiator end of the RFG byte protocol: serialises register commands onto an
// AXIS master and returns read-response bytes on an unbuffered response port.
module rfg_axis_protocol_initiator
    import rfg_protocol_pkg::*;
#(
    parameter logic [7:0]          TARGET_DEST  = 8'd0,
    parameter int unsigned         ID_WIDTH     = 8,
    parameter logic [ID_WIDTH-1:0] SOURCE_ID    = '0,
    parameter int unsigned         RESP_TIMEOUT = 65535
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic                cmd_incr,
    input  logic [3:0]          cmd_vchannel,
    input  logic [7:0]          cmd_address,
    input  logic [15:0]         cmd_length,
    input  logic [7:0]          wr_data,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic [7:0]          m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic [ID_WIDTH-1:0] m_axis_tid,
    output logic [7:0]          m_axis_tdest,
    input  logic [7:0]          s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic                s_axis_tlast,
    input  logic [ID_WIDTH-1:0] s_axis_tid,
    output logic [7:0]          rd_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic                rd_last,
    output logic                busy,
    output logic                err_length,
    output logic                err_timeout,
    output logic                err_tid
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(RESP_TIMEOUT - 1);

    state_t      state, next_state;
    header_t     hdr_q, cmd_hdr;
    logic [7:0]  addr_q;
    logic [15:0] remaining;
    logic [15:0] tcnt;
    logic [7:0]  tdata_q;
    logic        tvalid_q, tlast_q;

    logic cmd_hs, m_hs, wr_hs, s_hs, tid_ok, resp_timeout;

    assign cmd_hdr      = make_header(cmd_write, cmd_incr, cmd_vchannel);
    assign cmd_hs       = cmd_valid && cmd_ready;
    assign m_hs         = tvalid_q && m_axis_tready;
    assign wr_hs        = wr_valid && wr_ready;
    assign s_hs         = s_axis_tvalid && s_axis_tready;
    assign tid_ok       = (s_axis_tid == ID_WIDTH'(hdr_q.vchannel));
    // Fires on the edge at which the idle count would reach RESP_TIMEOUT.
    assign resp_timeout = (state == READ_WAIT) && !s_hs && (tcnt == TIMEOUT_LAST);

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tid    = SOURCE_ID;
    assign m_axis_tdest  = TARGET_DEST;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:       if (cmd_hs && cmd_length != '0) next_state = HEADER;
            HEADER:     if (m_hs) next_state = ADDRESS;
            ADDRESS:    if (m_hs) next_state = LENA;
            LENA:       if (m_hs) next_state = LENB;
            LENB:       if (m_hs) next_state = hdr_q.write ? WRITE_DATA : READ_WAIT;
            WRITE_DATA: if (m_hs && tlast_q) next_state = IDLE;
            READ_WAIT: begin
                if (s_hs && tid_ok && (remaining == 16'd1 || s_axis_tlast)) next_state = IDLE;
                else if (resp_timeout)                                      next_state = IDLE;
            end
            default:    next_state = IDLE;
        endcase
    end

    // The first payload byte may load while the length MSB is being accepted,
    // which keeps the frame at one byte per cycle under full throughput.
    always_comb begin
        cmd_ready     = (state == IDLE);
        busy          = (state != IDLE);
        wr_ready      = (!tvalid_q || m_axis_tready) && (remaining != '0) &&
                        ((state == WRITE_DATA) || (state == LENB && hdr_q.write));
        s_axis_tready = (state == READ_WAIT) ? rd_ready : 1'b1;
        rd_data       = s_axis_tdata;
        rd_valid      = (state == READ_WAIT) && s_axis_tvalid && tid_ok;
        rd_last       = (state == READ_WAIT) && (remaining == 16'd1);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hdr_q       <= '0;
            addr_q      <= '0;
            remaining   <= '0;
            tcnt        <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            err_length  <= 1'b0;
            err_tid     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            err_length  <= 1'b0;
            err_tid     <= 1'b0;
            err_timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_hs) begin
                        hdr_q     <= cmd_hdr;
                        addr_q    <= cmd_address;
                        remaining <= cmd_length;
                        if (cmd_length == '0) begin
                            err_length <= 1'b1;
                        end else begin
                            tdata_q  <= frame_byte(BYTE_HEADER, cmd_hdr, cmd_address, cmd_length);
                            tvalid_q <= 1'b1;
                            tlast_q  <= 1'b0;
                        end
                    end
                end
                HEADER:  if (m_hs) tdata_q <= frame_byte(BYTE_ADDRESS, hdr_q, addr_q, remaining);
                ADDRESS: if (m_hs) tdata_q <= frame_byte(BYTE_LEN_LSB, hdr_q, addr_q, remaining);
                LENA: begin
                    if (m_hs) begin
                        tdata_q <= frame_byte(BYTE_LEN_MSB, hdr_q, addr_q, remaining);
                        tlast_q <= hdr_q.read;
                    end
                end
                LENB, WRITE_DATA: begin
                    if (wr_hs) begin
                        tdata_q   <= wr_data;
                        tvalid_q  <= 1'b1;
                        tlast_q   <= (remaining == 16'd1);
                        remaining <= remaining - 16'd1;
                    end else if (m_hs) begin
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                    end
                end
                READ_WAIT: begin
                    if (s_hs) begin
                        tcnt <= '0;
                        if (!tid_ok) begin
                            err_tid <= 1'b1;
                        end else begin
                            if (remaining != '0) remaining <= remaining - 16'd1;
                            if (s_axis_tlast && remaining != 16'd1) err_length <= 1'b1;
                        end
                    end else if (resp_timeout) begin
                        tcnt        <= '0;
                        err_timeout <= 1'b1;
                    end else if (tcnt != '1) begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
